// File: rtl/axil_master_cmd.sv
// Single-outstanding AXI-Lite master: turns a valid/ready command into one AXI-Lite
// read or write and returns the data/response on a valid/ready response port.
module axil_master_cmd #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  // command port
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                    rsp_resp,
  // AXI-Lite write address
  output logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
  output logic                          m_axil_awvalid,
  input  logic                          m_axil_awready,
  // AXI-Lite write data
  output logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
  output logic                          m_axil_wvalid,
  input  logic                          m_axil_wready,
  // AXI-Lite write response
  input  logic [1:0]                    m_axil_bresp,
  input  logic                          m_axil_bvalid,
  output logic                          m_axil_bready,
  // AXI-Lite read address
  output logic [AXI_ADDR_WIDTH-1:0]     m_axil_araddr,
  output logic                          m_axil_arvalid,
  input  logic                          m_axil_arready,
  // AXI-Lite read data
  input  logic [AXI_DATA_WIDTH-1:0]     m_axil_rdata,
  input  logic [1:0]                    m_axil_rresp,
  input  logic                          m_axil_rvalid,
  output logic                          m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state;

  assign cmd_ready = (state == IDLE) && !areset;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= IDLE;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              m_axil_awaddr  <= cmd_addr;
              m_axil_wdata   <= cmd_wdata;
              m_axil_wstrb   <= cmd_wstrb;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= WR;
            end else begin
              m_axil_araddr  <= cmd_addr;
              m_axil_arvalid <= 1'b1;
              state          <= RD_ADDR;
            end
          end
        end
        WR: begin
          // AW and W retire independently; leave once neither is still pending.
          if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
          if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
            m_axil_bready <= 1'b1;
            state         <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axil_bvalid) begin
            rsp_resp      <= m_axil_bresp;
            rsp_rdata     <= '0;
            rsp_write     <= 1'b1;
            rsp_valid     <= 1'b1;
            m_axil_bready <= 1'b0;
            state         <= RSP;
          end
        end
        RD_ADDR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axil_rvalid) begin
            rsp_rdata     <= m_axil_rdata;
            rsp_resp      <= m_axil_rresp;
            rsp_write     <= 1'b0;
            rsp_valid     <= 1'b1;
            m_axil_rready <= 1'b0;
            state         <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_cmd.sv
// Bench for axil_master_cmd: directed latency/stall/reset cases plus a randomized run
// against a stalling memory slave, checked with a word-level memory reference.
module tb_axil_master_cmd;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          aclk;
  logic          areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rvalid = 1'b0;
  logic          rready;

  axil_master_cmd #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  // slave configuration: fixed wait cycles per channel, or random stalls when rnd=1
  bit       rnd = 1'b0;
  int       aw_fix = 0, w_fix = 0, ar_fix = 0, b_fix = 0, r_fix = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  function automatic int nw(input int f);
    return rnd ? int'($urandom_range(0, 3)) : f;
  endfunction

  // handshake capture and AXI / response stability monitor
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  bit aw_pend, w_pend, ar_pend, rsp_pend;
  logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
  logic [3:0]  p_wstrb;
  logic [1:0]  p_resp;
  logic        p_write;

  always @(posedge aclk) begin
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    b_hs  = bvalid && bready;
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    if (aw_hs) cap_awaddr = awaddr;
    if (w_hs) begin cap_wdata = wdata; cap_wstrb = wstrb; end
    if (ar_hs) cap_araddr = araddr;
    if (!areset) begin
      if (aw_pend && !(awvalid === 1'b1 && awaddr === p_awaddr)) viol++;
      if (w_pend && !(wvalid === 1'b1 && wdata === p_wdata && wstrb === p_wstrb)) viol++;
      if (ar_pend && !(arvalid === 1'b1 && araddr === p_araddr)) viol++;
      if (rsp_pend && !(rsp_valid === 1'b1 && rsp_rdata === p_rdata &&
                        rsp_resp === p_resp && rsp_write === p_write)) viol++;
      if (bready === 1'b1 && (awvalid === 1'b1 || wvalid === 1'b1)) viol++;
    end
    aw_pend  = !areset && awvalid && !awready;
    w_pend   = !areset && wvalid && !wready;
    ar_pend  = !areset && arvalid && !arready;
    rsp_pend = !areset && rsp_valid && !rsp_ready;
    p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb; p_araddr = araddr;
    p_rdata = rsp_rdata; p_resp = rsp_resp; p_write = rsp_write;
  end

  // memory slave, driven on the falling edge
  bit aw_have, w_have, ar_have, aw_arm, w_arm, ar_arm, b_arm, r_arm;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;

  always @(negedge aclk) begin
    if (areset) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_have = 0; w_have = 0; ar_have = 0;
      aw_arm = 0; w_arm = 0; ar_arm = 0; b_arm = 0; r_arm = 0;
    end else begin
      if (aw_hs) begin awready = 0; aw_have = 1; aw_arm = 0; end
      else if (awvalid && !aw_have && !awready) begin
        if (!aw_arm) begin aw_arm = 1; aw_wait = nw(aw_fix); end
        if (aw_wait == 0) awready = 1; else aw_wait--;
      end
      if (w_hs) begin wready = 0; w_have = 1; w_arm = 0; end
      else if (wvalid && !w_have && !wready) begin
        if (!w_arm) begin w_arm = 1; w_wait = nw(w_fix); end
        if (w_wait == 0) wready = 1; else w_wait--;
      end
      if (b_hs) begin bvalid = 0; aw_have = 0; w_have = 0; end
      else if (aw_have && w_have && !bvalid) begin
        if (!b_arm) begin b_arm = 1; b_wait = nw(b_fix); end
        if (b_wait == 0) begin
          b_arm = 0;
          mem[cap_awaddr[5:2]] = merge(mem[cap_awaddr[5:2]], cap_wdata, cap_wstrb);
          bresp = bresp_cfg;
          bvalid = 1;
        end else b_wait--;
      end
      if (ar_hs) begin arready = 0; ar_have = 1; ar_arm = 0; end
      else if (arvalid && !ar_have && !arready) begin
        if (!ar_arm) begin ar_arm = 1; ar_wait = nw(ar_fix); end
        if (ar_wait == 0) arready = 1; else ar_wait--;
      end
      if (r_hs) begin rvalid = 0; ar_have = 0; end
      else if (ar_have && !rvalid) begin
        if (!r_arm) begin r_arm = 1; r_wait = nw(r_fix); end
        if (r_wait == 0) begin
          r_arm = 0;
          rdata = mem[cap_araddr[5:2]];
          rresp = rresp_cfg;
          rvalid = 1;
        end else r_wait--;
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge aclk); n++; end
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    @(negedge aclk);
    cmd_valid = 0;
  endtask

  task automatic get_rsp(input int dly, output logic [31:0] d, output logic [1:0] r,
                         output logic w);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge aclk); n++; end
    chk("rsp_arrive", 64'(rsp_valid), 64'(1));
    repeat (dly) @(negedge aclk);
    d = rsp_rdata; r = rsp_resp; w = rsp_write;
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
  endtask

  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int dly, input string tag);
    logic [31:0] rd, ed;
    logic [1:0]  rr, er;
    logic        rw;
    issue(w, a, d, s);
    get_rsp(dly, rd, rr, rw);
    if (w) begin
      ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
      ed = 0; er = bresp_cfg;
    end else begin
      ed = ref_mem[a[5:2]]; er = rresp_cfg;
    end
    chk({tag, "_write"}, 64'(rw), 64'(w));
    chk({tag, "_rdata"}, 64'(rd), 64'(ed));
    chk({tag, "_resp"}, 64'(rr), 64'(er));
  endtask

  task automatic wr_stall(input bit aw_slow, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd, slow_exp;
    logic [1:0]  rr;
    logic        rw;
    aw_fix = aw_slow ? 3 : 0;
    w_fix  = aw_slow ? 0 : 3;
    slow_exp = aw_slow ? a : d;
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF;
    chk("stall_cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge aclk);
    cmd_valid = 0;
    chk("stall_c1_awvalid", 64'(awvalid), 64'(1));
    chk("stall_c1_wvalid", 64'(wvalid), 64'(1));
    for (int c = 2; c <= 4; c++) begin
      @(negedge aclk);
      chk("stall_fast_valid", 64'(aw_slow ? wvalid : awvalid), 64'(0));
      chk("stall_slow_valid", 64'(aw_slow ? awvalid : wvalid), 64'(1));
      chk("stall_slow_data", 64'(aw_slow ? awaddr : wdata), 64'(slow_exp));
      chk("stall_bready_low", 64'(bready), 64'(0));
    end
    @(negedge aclk);
    chk("stall_slow_dropped", 64'(aw_slow ? awvalid : wvalid), 64'(0));
    chk("stall_bready_high", 64'(bready), 64'(1));
    get_rsp(0, rd, rr, rw);
    ref_mem[a[5:2]] = d;
    chk("stall_rsp_write", 64'(rw), 64'(1));
    chk("stall_rsp_rdata", 64'(rd), 64'(0));
    aw_fix = 0; w_fix = 0;
  endtask

  logic [31:0] t_d;
  logic [1:0]  t_r;
  logic        t_w;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'hA500_0000 | 32'(i);
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h1234_5678;
    ref_mem[0] = 32'h1234_5678;
    repeat (3) @(negedge aclk);

    // reset state
    chk("rst_cmd_ready_in_reset", 64'(cmd_ready), 64'(0));
    chk("rst_awvalid", 64'(awvalid), 64'(0));
    chk("rst_wvalid", 64'(wvalid), 64'(0));
    chk("rst_arvalid", 64'(arvalid), 64'(0));
    chk("rst_bready", 64'(bready), 64'(0));
    chk("rst_rready", 64'(rready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_write", 64'(rsp_write), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_awaddr", 64'(awaddr), 64'(0));
    areset = 0;
    @(negedge aclk);
    chk("rst_cmd_ready_after", 64'(cmd_ready), 64'(1));

    // zero-wait write: AW+W cycle 1, B cycle 2, rsp_valid cycle 3
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h4; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    chk("w0_cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge aclk);
    cmd_valid = 0;
    chk("w0_c1_awvalid", 64'(awvalid), 64'(1));
    chk("w0_c1_wvalid", 64'(wvalid), 64'(1));
    chk("w0_c1_awaddr", 64'(awaddr), 64'(32'h4));
    chk("w0_c1_wdata", 64'(wdata), 64'(32'hDEAD_BEEF));
    chk("w0_c1_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge aclk);
    chk("w0_c2_awvalid", 64'(awvalid), 64'(0));
    chk("w0_c2_wvalid", 64'(wvalid), 64'(0));
    chk("w0_c2_bready", 64'(bready), 64'(1));
    chk("w0_c2_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge aclk);
    chk("w0_c3_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("w0_c3_rsp_write", 64'(rsp_write), 64'(1));
    chk("w0_c3_rsp_resp", 64'(rsp_resp), 64'(0));
    chk("w0_c3_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("w0_c3_bready", 64'(bready), 64'(0));
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
    chk("w0_rsp_consumed", 64'(rsp_valid), 64'(0));
    chk("w0_cmd_ready_back", 64'(cmd_ready), 64'(1));
    ref_mem[1] = 32'hDEAD_BEEF;

    // write with AW stalled, then with W stalled
    wr_stall(1'b1, 32'h0000_000C, 32'hCAFE_0001);
    wr_stall(1'b0, 32'h0000_0010, 32'hCAFE_0002);

    // read with SLVERR after 2 wait cycles on R
    r_fix = 2; rresp_cfg = 2'd2;
    run_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, "rd_slverr");
    r_fix = 0; rresp_cfg = 2'd0;

    // response back-pressure with the next command already waiting
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8;
    chk("bp_cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge aclk);
    cmd_write = 1; cmd_addr = 32'h14; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'h3;
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge aclk); n++; end
    end
    chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    for (int c = 0; c < 5; c++) begin
      chk("bp_cmd_ready_low", 64'(cmd_ready), 64'(0));
      chk("bp_rsp_rdata", 64'(rsp_rdata), 64'(ref_mem[2]));
      @(negedge aclk);
    end
    chk("bp_rsp_write", 64'(rsp_write), 64'(0));
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
    chk("bp_rsp_dropped", 64'(rsp_valid), 64'(0));
    chk("bp_cmd_ready_next", 64'(cmd_ready), 64'(1));
    @(negedge aclk);
    cmd_valid = 0;
    chk("bp_next_awvalid", 64'(awvalid), 64'(1));
    get_rsp(0, t_d, t_r, t_w);
    ref_mem[5] = merge(ref_mem[5], 32'h0BAD_F00D, 4'h3);
    chk("bp_next_rsp_write", 64'(t_w), 64'(1));

    // reset while waiting in WR_RESP with bvalid low
    b_fix = 8;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h18; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
    @(negedge aclk);
    cmd_valid = 0;
    begin
      int n;
      n = 0;
      while (!bready && n < 20) begin @(negedge aclk); n++; end
    end
    chk("mid_bready_reached", 64'(bready), 64'(1));
    chk("mid_bvalid_low", 64'(bvalid), 64'(0));
    areset = 1; b_fix = 0;
    @(negedge aclk);
    chk("mid_awvalid", 64'(awvalid), 64'(0));
    chk("mid_wvalid", 64'(wvalid), 64'(0));
    chk("mid_arvalid", 64'(arvalid), 64'(0));
    chk("mid_bready", 64'(bready), 64'(0));
    chk("mid_rready", 64'(rready), 64'(0));
    chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge aclk);
    areset = 0;
    @(negedge aclk);
    chk("mid_cmd_ready", 64'(cmd_ready), 64'(1));
    run_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, "post_rst_rd");

    // randomized traffic with random stalls
    rnd = 1;
    for (int i = 0; i < 100; i++) begin
      logic        w;
      logic [31:0] a, d;
      logic [3:0]  s;
      w = 1'($urandom_range(0, 1));
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom();
      s = 4'($urandom_range(0, 15));
      bresp_cfg = 2'($urandom_range(0, 3));
      rresp_cfg = 2'($urandom_range(0, 3));
      run_cmd(w, a, d, s, int'($urandom_range(0, 2)), "rand");
    end
    rnd = 0;
    repeat (2) @(negedge aclk);
    chk("axi_stability_violations", 64'(viol), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_master_cmd.md
Name: axil_master_cmd

Overview:
Single-outstanding AXI-Lite master. It turns a simple valid/ready command port into AXI-Lite read or write transactions and returns the data/response on a valid/ready response port. It is the initiator counterpart to the team's AXI-Lite slave blocks, used by local controllers, sequencers and the loopback bench to drive register slaves.

Parameters:
AXI_DATA_WIDTH, 32, data bus width in bits; multiple of 8.
AXI_ADDR_WIDTH, 32, address bus width in bits.

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AXI_ADDR_WIDTH  byte address
cmd_wdata  in  AXI_DATA_WIDTH  write data (ignored on read)
cmd_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes (ignored on read)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_write  out  1  response belongs to a write
rsp_rdata  out  AXI_DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  BRESP or RRESP
m_axil_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI-Lite master channels, widths per parameters, directions mirror a slave port.

Behaviour:
- States: IDLE, WR (AW and W pending), WR_RESP, RD_ADDR, RD_DATA, RSP.
- cmd_ready = (state==IDLE) && !areset; combinational. No new command is accepted until the response has been consumed.
- IDLE: on cmd_valid&&cmd_ready, latch addr/wdata/wstrb/write. Write -> WR with awvalid=wvalid=1 from the next cycle. Read -> RD_ADDR with arvalid=1 from the next cycle.
- WR: awvalid and wvalid drop independently, on the cycle after their own handshake. Either channel may complete first or both in the same cycle. When both are done, go to WR_RESP with bready=1.
- WR_RESP: on bvalid&&bready, capture bresp into rsp_resp, set rsp_rdata=0 and rsp_write=1, drop bready, go to RSP.
- RD_ADDR: on arvalid&&arready, drop arvalid, go to RD_DATA with rready=1.
- RD_DATA: on rvalid&&rready, capture rdata/rresp, set rsp_write=0, drop rready, go to RSP.
- RSP: rsp_valid=1; all rsp_* outputs stable until rsp_valid&&rsp_ready, then go to IDLE. cmd_ready rises the following cycle.
- AXI rules:
  - valid never depends combinationally on ready.
  - awaddr/wdata/wstrb/araddr come from registers and stay stable while their valid is high.
  - A valid, once asserted, is held until its handshake.
- Minimum latency with an always-ready, zero-wait slave:
  - Write: accept at cycle 0, AW+W handshake cycle 1, B handshake cycle 2, rsp_valid cycle 3.
  - Read: AR handshake cycle 1, R handshake cycle 2, rsp_valid cycle 3.
- No timeout: the block waits indefinitely for slave ready/valid.
- Reset values: state=IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_write = 0; address/data/strb outputs, rsp_rdata, rsp_resp = 0.
- Reset mid-transaction: all valids/readies drop on the next edge, and any in-flight response is discarded. The slave must be reset together with the master.
- Unused address/data outputs are held at their last value, not X.

Test Plan:
- Write 0x0000_0004 / 0xDEADBEEF / wstrb 0xF, slave always ready, bresp=OKAY -> AW+W handshake cycle 1, rsp_valid cycle 3, rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Write with awready delayed 3 cycles and wready immediate -> wvalid drops after cycle 1, awvalid held with stable awaddr until cycle 4, bready only after both done; repeat with wready delayed -> symmetric behaviour.
- Read 0x0000_0000 with slave returning 0x1234_5678 and rresp=SLVERR(2) after 2 wait cycles -> rsp_rdata=0x12345678, rsp_resp=2, rsp_write=0.
- rsp_ready held low 5 cycles with cmd_valid high -> rsp_* stable, cmd_ready=0 throughout, next command accepted the cycle after rsp_ready.
- areset asserted in WR_RESP with bvalid low -> next cycle all valids/readies 0, rsp_valid=0, cmd_ready=1 after release; a following read completes normally.
- 100 back-to-back random read/write commands against a memory-model slave with random ready/valid stalls -> every read returns the last data written with correct strobes; zero AXI stability violations.
